// File: rtl/dpram_port_arbiter.sv
// Round-robin front end for the shared 256x8 dual-port RAM.
// Registers RAM commands and routes read returns to their requester.
module dpram_rr_arb #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] sel,
  output logic          hit
);

  logic [PW-1:0]  ptr;
  logic [PW-1:0]  nxt;
  logic [PW-1:0]  off;
  logic [PW:0]    sum;
  logic [2*N-1:0] rot;

  // Rotate so the pointer's requester sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot = {req, req} >> ptr;
    off = '0;
    hit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = PW'(k);
        hit = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PW+1)'(N)) begin
      sel = PW'(sum - (PW+1)'(N));
    end else begin
      sel = PW'(sum);
    end
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = rst_n && hit && (sel == PW'(i));
    end
    if (sel == PW'(N - 1)) begin
      nxt = '0;
    end else begin
      nxt = sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= nxt;
    end
  end

endmodule

module dpram_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        wr_req,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        wr_gnt,
  input  logic [NUM_REQ-1:0]        rd_req,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rd_gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      ram_write_en,
  output logic [ADDR_W-1:0]         ram_write_addr,
  output logic [DATA_W-1:0]         ram_d_in,
  output logic                      ram_read_en,
  output logic [ADDR_W-1:0]         ram_read_addr,
  input  logic [DATA_W-1:0]         ram_d_out
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      wsel;
  logic [PW-1:0]      rsel;
  logic               whit;
  logic               rhit;
  logic [NUM_REQ-1:0] rd_id;
  logic               byp;
  logic [DATA_W-1:0]  byp_data;

  dpram_rr_arb #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .gnt   (wr_gnt),
    .sel   (wsel),
    .hit   (whit)
  );

  dpram_rr_arb #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .gnt   (rd_gnt),
    .sel   (rsel),
    .hit   (rhit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_write_en   <= 1'b0;
      ram_write_addr <= '0;
      ram_d_in       <= '0;
      ram_read_en    <= 1'b0;
      ram_read_addr  <= '0;
      rd_id          <= '0;
      rd_valid       <= '0;
      byp            <= 1'b0;
      byp_data       <= '0;
    end else begin
      ram_write_en <= whit;
      if (whit) begin
        ram_write_addr <= wr_addr[wsel*ADDR_W +: ADDR_W];
        ram_d_in       <= wr_data[wsel*DATA_W +: DATA_W];
      end
      ram_read_en <= rhit;
      rd_id       <= rd_gnt;
      if (rhit) begin
        ram_read_addr <= rd_addr[rsel*ADDR_W +: ADDR_W];
      end
      rd_valid <= ram_read_en ? rd_id : '0;
      // Same-cycle collision: return the new data regardless of RAM behaviour.
      byp      <= ram_read_en && ram_write_en &&
                  (ram_read_addr == ram_write_addr);
      byp_data <= ram_d_in;
    end
  end

  always_comb begin
    rd_data = '0;
    if (|rd_valid) begin
      rd_data = byp ? byp_data : ram_d_out;
    end
  end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Round-robin arbiter that shares the single write port and single read port of the team's 256x8 synchronous dual-port RAM among NUM_REQ requesters. Each requester has an independent valid/grant write channel and read channel. The block registers RAM commands, tracks in-flight reads, and routes returned data back to the requester that issued the read. It sits between the client blocks and the RAM instance, and is the only driver of the RAM ports.

## Interface

- NUM_REQ, 2: number of requesters, 2..8.
- ADDR_W, 8: RAM address width.
- DATA_W, 8: RAM data width.

Ports:

- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_req  in  NUM_REQ  per-requester write request; hold until granted.
- wr_addr  in  NUM_REQ*ADDR_W  flattened write addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- wr_data  in  NUM_REQ*DATA_W  flattened write data.
- wr_gnt  out  NUM_REQ  one-hot write grant (combinational).
- rd_req  in  NUM_REQ  per-requester read request; hold until granted.
- rd_addr  in  NUM_REQ*ADDR_W  flattened read addresses.
- rd_gnt  out  NUM_REQ  one-hot read grant (combinational).
- rd_valid  out  NUM_REQ  one-hot, registered; the read data is for requester i.
- rd_data  out  DATA_W  shared read-return data; valid only when rd_valid is non-zero.
- ram_write_en  out  1  RAM write enable.
- ram_write_addr  out  ADDR_W  RAM write address.
- ram_d_in  out  DATA_W  RAM write data.
- ram_read_en  out  1  RAM read enable.
- ram_read_addr  out  ADDR_W  RAM read address.
- ram_d_out  in  DATA_W  RAM read data; valid the cycle after ram_read_en is sampled.

## Operation

- Write and read arbiters are independent. Both may grant in the same cycle.
- Arbitration: each arbiter has a pointer wptr or rptr, reset to 0.
  - The grant goes to the first requester with req=1, searching from the pointer upward modulo NUM_REQ.
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no request, the pointer holds.
- A transfer occurs when req[i] and gnt[i] are both high. At most one bit of gnt is set. A grant is never issued without its request.
- Fairness: a continuously asserted request is granted within NUM_REQ cycles.
- Command stage (registered): on a write transfer at cycle T, ram_write_en=1 with the granted address and data during T+1. Read commands work the same way.
- Read tracking: a one-hot id register and a valid bit travel with each read.
  - The RAM returns data in T+2.
  - rd_valid[id]=1 during T+2, and rd_data is driven then.
  - Back-to-back reads are fully pipelined, one per cycle.
- Same-address bypass: when the write command and read command in the same cycle target the same address, the controller records a bypass flag and the write data. In the return cycle, rd_data is the bypassed write data instead of ram_d_out. This makes the result new-data, independent of the RAM's collision behaviour.
- A read of an address written in an earlier command cycle returns the RAM contents. The RAM holds the write by then.

## Timing

- Reset values, all outputs 0: ram_write_en, ram_read_en, ram_write_addr, ram_read_addr, ram_d_in, rd_valid, rd_data. Pointers are 0, bypass flag is 0.
- wr_gnt and rd_gnt are 0 while rst_n=0.
- Latency:
  - Write: handshake at T, RAM write at the T+1 edge.
  - Read: handshake at T, rd_valid at T+2.
- Throughput: one write and one read per cycle, sustained.
- The grant depends combinationally on req and the pointer only. Requesters must not make req depend combinationally on gnt.
- Reset asserted mid-operation:
  - In-flight reads are dropped, and rd_valid stays 0 for them after reset.
  - No ram_write_en pulse is issued for a handshake that was overlapped by reset.
- Pointer wrap: with NUM_REQ=2, the pointer toggles 0↔1. Non-power-of-two NUM_REQ wraps from NUM_REQ-1 to 0.

## Test plan

- Reset: hold rst_n=0 with all req=1. Required: every grant and output is 0. Release; the first cycle grants requester 0 on both ports.
- Single write then read: req0 writes addr 0x12 data 0xA5 at T; req0 reads 0x12 at T+2. Required: ram_write_en at T+1; rd_valid=01 with rd_data=0xA5 at T+4.
- Round-robin: both requesters hold wr_req for 6 cycles. Required: grants 01,10,01,10,01,10. Pointer ends at 0.
- Collision bypass: at cycle T, req0 writes 0x40←0x3C while req1 reads 0x40 (old contents 0x00). Required: rd_valid=10, rd_data=0x3C at T+2.
- Pipelined reads: req0 and req1 alternately read addresses 0x01..0x04 (preloaded 0x11..0x44) on consecutive cycles. Required: four consecutive rd_valid pulses with correct one-hot id and data 0x11..0x44.
- Mid-read reset: read handshake at T, rst_n low at T+1. Required: no rd_valid at T+2. After release, the pointers are 0.
